rsa_modexp_core: RTL

Parametrised modular exponentiation engine computing o_result = i_a^i_e mod i_n for a WIDTH-bit odd modulus. It integrates the Montgomery pre-transform and two bit-serial Montgomery multipliers, so no external trans/mul sub-blocks or call handshakes are needed. It replaces the fixed 256-bit core between the RSA wrapper's input registers and its output shifter. The start pulse and the valid/ready result port connect straight to the wrapper FSM.

---
 rtl/rsa_modexp_core_if.sv | 24 ++
 rtl/rsa_modexp_core.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core_if.sv
// Request/result port of rsa_modexp_core: operands and start in, result with valid/ready out.
interface rsa_modexp_core_if #(
    parameter int WIDTH = 256
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_e;
    logic [WIDTH-1:0] i_n;
    logic             i_ready;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;
    logic             o_err;

    modport master (
        output i_start, i_a, i_e, i_n, i_ready,
        input  o_busy, o_valid, o_result, o_err
    );

    modport slave (
        input  i_start, i_a, i_e, i_n, i_ready,
        output o_busy, o_valid, o_result, o_err
    );
endinterface

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation a^e mod n using a Montgomery pre-transform and two bit-serial Montgomery units.
// Build option RSA_EARLY_EXIT_EN: stop as soon as the remaining exponent bits are zero (not constant-time).
//
// state  | meaning
// IDLE   | waiting for i_start, operands not latched
// PREP   | WIDTH doublings mod n: t = a*2^WIDTH mod n
// MUL    | WIDTH+1 cycles per exponent bit: t = MM(t,t), res = MM(res,t) when e bit set
// FIN    | register the result (or 0 on even modulus)
// DONE   | o_valid held until i_ready
module rsa_modexp_core #(
    parameter int WIDTH = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    rsa_modexp_core_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0]    CNT_PREP = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_MUL  = CW'(WIDTH);
    localparam logic [KW-1:0]    BIT_LAST = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH+1:0] ms_q, ms_d;
    logic [WIDTH+1:0] mr_q, mr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]    bit_q, bit_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   prep_dbl;
    logic [WIDTH-1:0] prep_next;
    logic [WIDTH-1:0] s_fin;
    logic [WIDTH-1:0] r_fin;
    logic             last_bit;
    logic             skip_mul;

    // One Montgomery iteration; the accumulator stays below 4n so WIDTH+2 bits never overflow.
    function automatic logic [WIDTH+1:0] mm_step(input logic [WIDTH+1:0] m,
                                                 input logic             xbit,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] s;
        s = m + (xbit ? {2'b00, y} : '0);
        if (s[0])
            s = s + {2'b00, n};
        return s >> 1;
    endfunction

    function automatic logic [WIDTH-1:0] mm_final(input logic [WIDTH+1:0] m,
                                                  input logic [WIDTH-1:0] n);
        if (m >= {2'b00, n})
            return WIDTH'(m - {2'b00, n});
        else
            return WIDTH'(m);
    endfunction

    assign prep_dbl  = {t_q, 1'b0};
    assign prep_next = (prep_dbl >= {1'b0, n_q}) ? WIDTH'(prep_dbl - {1'b0, n_q})
                                                 : prep_dbl[WIDTH-1:0];
    assign s_fin = mm_final(ms_q, n_q);
    assign r_fin = mm_final(mr_q, n_q);

`ifdef RSA_EARLY_EXIT_EN
    // e_q shifts right once per finished bit, so e_q[0] is always the current bit.
    assign skip_mul = (e_q == '0);
    assign last_bit = (bit_q == '0) || (e_q[WIDTH-1:1] == '0);
`else
    assign skip_mul = 1'b0;
    assign last_bit = (bit_q == '0);
`endif

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        e_d      = e_q;
        t_d      = t_q;
        res_d    = res_q;
        xs_d     = xs_q;
        xr_d     = xr_q;
        ms_d     = ms_q;
        mr_d     = mr_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        err_d    = err_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    n_d   = bus.i_n;
                    e_d   = bus.i_e;
                    t_d   = bus.i_a;
                    res_d = ONE;
                    ms_d  = '0;
                    mr_d  = '0;
                    cnt_d = CNT_PREP;
                    bit_d = BIT_LAST;
                    err_d = ~bus.i_n[0];
                    state_d = bus.i_n[0] ? S_PREP : S_FIN;
                end
            end
            S_PREP: begin
                t_d = prep_next;
                if (cnt_q == '0) begin
                    xs_d    = prep_next;
                    xr_d    = res_q;
                    cnt_d   = CNT_MUL;
                    state_d = skip_mul ? S_FIN : S_MUL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MUL: begin
                if (cnt_q != '0) begin
                    ms_d = mm_step(ms_q, xs_q[0], t_q, n_q);
                    if (e_q[0])
                        mr_d = mm_step(mr_q, xr_q[0], t_q, n_q);
                    xs_d  = xs_q >> 1;
                    xr_d  = xr_q >> 1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    t_d = s_fin;
                    if (e_q[0])
                        res_d = r_fin;
                    xs_d  = s_fin;
                    xr_d  = e_q[0] ? r_fin : res_q;
                    e_d   = e_q >> 1;
                    ms_d  = '0;
                    mr_d  = '0;
                    cnt_d = CNT_MUL;
                    if (last_bit)
                        state_d = S_FIN;
                    else
                        bit_d = bit_q - 1'b1;
                end
            end
            S_FIN: begin
                result_d = err_q ? '0 : res_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.i_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            e_q      <= '0;
            t_q      <= '0;
            res_q    <= '0;
            xs_q     <= '0;
            xr_q     <= '0;
            ms_q     <= '0;
            mr_q     <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            e_q      <= e_d;
            t_q      <= t_d;
            res_q    <= res_d;
            xs_q     <= xs_d;
            xr_q     <= xr_d;
            ms_q     <= ms_d;
            mr_q     <= mr_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_err    = err_q && (state_q == S_DONE);
    assign bus.o_result = result_q;
endmodule
